// File: rtl/reg_file_mp.sv
// Two-read/one-write register file with bulk-clear engine and optional write-to-read bypass.
// Latency: reads are combinational (0 cycles); writes land at the rising edge; a clear takes DEPTH cycles.
// Backpressure: none; writes arriving during a clear are dropped and flagged on wr_drop.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   raddr1/2, rdata1/2   combinational read ports
//   we, jreg, waddr,     write port; jreg=1 inhibits the write
//   wdata
//   wr_drop              one-cycle pulse: a write was discarded because a clear was running
//   clr_req              bulk-clear request, sampled at the rising edge
//   clr_busy             high while the clear sequence runs
//   clr_done             one-cycle pulse after the last entry has been cleared
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic              jreg,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              wr_drop,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state;
    state_t            nextState;
    logic [ADDR_W:0]   clrCnt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              wrAttempt;
    logic              wrEff;
    logic              lastClr;
    logic              clrDone;
    logic              wrDrop;

    assign wrAttempt = we && !jreg;
    assign wrEff     = wrAttempt && (state == IDLE) && !((ZERO_R0 != 0) && (waddr == '0));
    assign lastClr   = (clrCnt == (ADDR_W + 1)'(DEPTH - 1));

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM: next state; clr_req during CLEAR is deliberately ignored
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (clr_req) nextState = CLEAR;
            CLEAR:   if (lastClr) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        clr_busy = (state == CLEAR);
    end

    // Clear counter parks at DEPTH-1 instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clrCnt <= '0;
        end else if ((state == IDLE) && clr_req) begin
            clrCnt <= '0;
        end else if ((state == CLEAR) && !lastClr) begin
            clrCnt <= clrCnt + 1'b1;
        end
    end

    // Storage: clear engine owns the array while CLEAR; wrEff is already gated to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[clrCnt[ADDR_W-1:0]] <= '0;
        end else if (wrEff) begin
            regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clrDone <= 1'b0;
            wrDrop  <= 1'b0;
        end else begin
            clrDone <= (state == CLEAR) && lastClr;
            wrDrop  <= wrAttempt && (state == CLEAR);
        end
    end

    assign clr_done = clrDone;
    assign wr_drop  = wrDrop;

    // Zero-forcing (reset, CLEAR, hardwired r0) overrides any forwarded data
    function automatic logic [DATA_W-1:0] readPort(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              fwd,
        input logic [DATA_W-1:0] fwdDat,
        input logic              blank
    );
        logic [DATA_W-1:0] r;
        r = fwd ? fwdDat : stored;
        if ((ZERO_R0 != 0) && (addr == '0)) r = '0;
        if (blank) r = '0;
        return r;
    endfunction

    logic fwd1;
    logic fwd2;
    logic blank;

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = wrEff && (raddr1 == waddr);
    assign fwd2 = wrEff && (raddr2 == waddr);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign blank  = rst || (state == CLEAR);
    assign rdata1 = readPort(raddr1, regs[raddr1], fwd1, wdata, blank);
    assign rdata2 = readPort(raddr2, regs[raddr2], fwd2, wdata, blank);

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp with default parameters (32x32, ZERO_R0=1).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_reg_file_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        we = 1'b0;
    logic        jreg = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        wr_drop;
    logic        clr_req = 1'b0;
    logic        clr_busy;
    logic        clr_done;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .we       (we),
        .jreg     (jreg),
        .waddr    (waddr),
        .wdata    (wdata),
        .wr_drop  (wr_drop),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    always #5 clk = ~clk;

    int          nCmp = 0;
    int          nBad = 0;
    logic [31:0] model [32];
    logic [31:0] expQ [$];
    string       tagQ [$];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input string tag, input logic [31:0] v);
        tagQ.push_back(tag);
        expQ.push_back(v);
    endtask

    task automatic popCheck(input logic [31:0] obs);
        if (expQ.size() == 0) begin
            checkVal("scoreboard_underflow", obs, ~obs);
        end else begin
            checkVal(tagQ.pop_front(), obs, expQ.pop_front());
        end
    endtask

    function automatic logic [31:0] modelRd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    // Called right after a negedge; samples 1 time unit later.
    task automatic readBoth(input logic [4:0] a1, input logic [4:0] a2, input string tag);
        raddr1 = a1;
        raddr2 = a2;
        pushExp($sformatf("%s_p1_r%0d", tag, a1), modelRd(a1));
        pushExp($sformatf("%s_p2_r%0d", tag, a2), modelRd(a2));
        #1;
        popCheck(rdata1);
        popCheck(rdata2);
    endtask

    task automatic writeReg(input logic [4:0] a, input logic [31:0] d, input logic jr);
        @(negedge clk);
        we = 1'b1; jreg = jr; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0; jreg = 1'b0;
        if (!jr && a != 5'd0) model[a] = d;
    endtask

    task automatic readAll(input string tag);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            readBoth(5'(i), 5'(31 - i), tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busyCnt;
        int doneCnt;
        int dropCnt;
        int doneAt;
        int lastBusyAt;
        logic [31:0] dropVal;

        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        // Reset state
        #1;
        checkVal("rst_busy", {31'd0, clr_busy}, 32'd0);
        checkVal("rst_done", {31'd0, clr_done}, 32'd0);
        checkVal("rst_drop", {31'd0, wr_drop}, 32'd0);
        pushExp("rst_rdata1", 32'd0);
        popCheck(rdata1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        readAll("post_reset");

        // Basic write / dual read
        writeReg(5'd5, 32'hDEADBEEF, 1'b0);
        readBoth(5'd5, 5'd5, "wr5");

        // Hardwired r0 and jump-register inhibit
        writeReg(5'd0, 32'h12345678, 1'b0);
        readBoth(5'd0, 5'd0, "r0");
        writeReg(5'd7, 32'h77777777, 1'b1);
        checkVal("jreg_drop", {31'd0, wr_drop}, 32'd0);
        readBoth(5'd7, 5'd5, "jreg");

        // Same-cycle read of a written address
        @(negedge clk);
        we = 1'b1; jreg = 1'b0; waddr = 5'd3; wdata = 32'hA5A5A5A5;
        raddr1 = 5'd3; raddr2 = 5'd5;
`ifdef REGFILE_BYPASS_EN
        pushExp("same_cycle_r3", 32'hA5A5A5A5);
`else
        pushExp("same_cycle_r3", model[3]);
`endif
        pushExp("same_cycle_r5", model[5]);
        #1;
        popCheck(rdata1);
        popCheck(rdata2);
        @(negedge clk);
        we = 1'b0;
        model[3] = 32'hA5A5A5A5;
        readBoth(5'd3, 5'd3, "next_cycle");

        // Fill r1..r31
        for (int i = 1; i < 32; i++) writeReg(5'(i), 32'h80000000 | (32'(i) * 32'h01010101), 1'b0);
        readBoth(5'd9, 5'd31, "filled");

        // Clear with a simultaneous write, a dropped write and an ignored re-request
        @(negedge clk);
        clr_req = 1'b1; we = 1'b1; waddr = 5'd20; wdata = 32'hCAFEF00D;
        busyCnt = 0; doneCnt = 0; dropCnt = 0; doneAt = -1; lastBusyAt = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            clr_req = (k == 8);
            we = (k == 5);
            waddr = 5'd9; wdata = 32'h99999999;
            raddr1 = 5'd9; raddr2 = 5'd20;
            #1;
            if (clr_busy) begin
                busyCnt++;
                lastBusyAt = k;
                pushExp("during_clr_p1", 32'd0);
                pushExp("during_clr_p2", 32'd0);
                popCheck(rdata1);
                popCheck(rdata2);
            end
            if (clr_done) begin doneCnt++; doneAt = k; end
            if (wr_drop) dropCnt++;
        end
        we = 1'b0; clr_req = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        checkVal("clr_busy_len", 32'(busyCnt), 32'd32);
        checkVal("clr_done_cnt", 32'(doneCnt), 32'd1);
        checkVal("clr_done_pos", 32'(doneAt), 32'(lastBusyAt + 1));
        checkVal("wr_drop_cnt", 32'(dropCnt), 32'd1);
        readAll("post_clear");

        // Writes accepted after clear
        writeReg(5'd9, 32'h0BADF00D, 1'b0);
        readBoth(5'd9, 5'd0, "after_clr_wr");

        // Reset mid-clear
        writeReg(5'd31, 32'h31313131, 1'b0);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        doneCnt = 0;
        repeat (9) begin
            @(negedge clk);
            if (clr_done) doneCnt++;
        end
        #2;
        checkVal("busy_before_rst", {31'd0, clr_busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkVal("busy_async_drop", {31'd0, clr_busy}, 32'd0);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        pushExp("in_reset_r31", 32'd0);
        raddr1 = 5'd31;
        #1;
        popCheck(rdata1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (clr_done) doneCnt++;
        end
        checkVal("rst_abort_done", 32'(doneCnt), 32'd0);
        checkVal("rst_abort_busy", {31'd0, clr_busy}, 32'd0);
        readAll("post_abort");

        dropVal = 32'(expQ.size());
        checkVal("scoreboard_drained", dropVal, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
